// File: rtl/bias_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bias_stream_ctrl
// Brief    : Streams KERN_NUM ROM bias words PIX_NUM times per frame through a
//            2-entry output FIFO. Option macro: BIAS_STREAM_LOOP_EN (auto-restart).
// Revision : 1.0
// ============================================================================
module bias_stream_ctrl #(
    parameter int KERN_NUM = 16,
    parameter int PIX_NUM  = 64,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = $clog2(KERN_NUM)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    output logic [ADDR_W-1:0] bias_V_address0,
    output logic              bias_V_ce0,
    input  logic [DATA_W-1:0] bias_V_q0,
    output logic [DATA_W-1:0] output_V_din,
    input  logic              output_V_full_n,
    output logic              output_V_write
);
    localparam int                PIX_W       = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
    localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(KERN_NUM - 1);
    localparam logic [PIX_W-1:0]  C_PIX_LAST  = PIX_W'(PIX_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]  r_pix;
    logic              r_inflight;
    logic [1:0]        r_count;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [DATA_W-1:0] r_mem [2];
    logic              r_done;

    logic [1:0]        w_occ;
    logic              w_ce0;
    logic              w_write;
    logic              w_last_read;
    logic              w_frame_end;

    // Words owned by the block: buffered plus the one arriving from the ROM.
    assign w_occ = r_count + {1'b0, r_inflight};

    always_comb begin
        w_state_next = r_state;
        w_write      = ((r_count != 2'd0) || r_inflight) && output_V_full_n;
        w_ce0        = 1'b0;
        w_last_read  = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            IDLE: begin
                if (ap_start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_ce0       = (w_occ != 2'd2) || w_write;
                w_last_read = w_ce0 && (r_addr == C_ADDR_LAST) && (r_pix == C_PIX_LAST);
                if (w_last_read) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_frame_end = (w_occ == 2'd0) || ((w_occ == 2'd1) && w_write);
                if (w_frame_end) begin
`ifdef BIAS_STREAM_LOOP_EN
                    w_state_next = RUN;
`else
                    w_state_next = IDLE;
`endif
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_frame_end;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_addr     <= '0;
            r_pix      <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_ce0;
            if (w_ce0) begin
                if (r_addr == C_ADDR_LAST) begin
                    r_addr <= '0;
                    r_pix  <= (r_pix == C_PIX_LAST) ? '0 : r_pix + 1'b1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    // Arriving words are always stored; a same-cycle pop skips past them.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            if (r_inflight) begin
                r_mem[r_wr_ptr] <= bias_V_q0;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_write) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_write};
        end
    end

    assign ap_idle         = (r_state == IDLE);
    assign ap_done         = r_done;
    assign bias_V_address0 = r_addr;
    assign bias_V_ce0      = w_ce0;
    assign output_V_write  = w_write;
    assign output_V_din    = (r_count != 2'd0) ? r_mem[r_rd_ptr] :
                             (r_inflight ? bias_V_q0 : '0);

endmodule
`default_nettype wire

// File: tb/tb_bias_stream_ctrl.sv
`default_nettype none
// Testbench for bias_stream_ctrl: KERN_NUM=4, PIX_NUM=3, ROM={10,20,30,40};
// per-cycle scoreboard plus directed literal checks.
module tb_bias_stream_ctrl;
    localparam int KERN = 4;
    localparam int PIX  = 3;
    localparam int DW   = 16;
    localparam int AW   = 2;

    logic          clk;
    logic          rst_n;
    logic          ap_start;
    logic          ap_idle;
    logic          ap_done;
    logic [AW-1:0] addr;
    logic          ce0;
    logic [DW-1:0] q0;
    logic [DW-1:0] din;
    logic          full_n;
    logic          wr;

    logic [DW-1:0] rom [KERN] = '{16'd10, 16'd20, 16'd30, 16'd40};

    bias_stream_ctrl #(
        .KERN_NUM(KERN),
        .PIX_NUM (PIX),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .ap_clk         (clk),
        .ap_rst_n       (rst_n),
        .ap_start       (ap_start),
        .ap_idle        (ap_idle),
        .ap_done        (ap_done),
        .bias_V_address0(addr),
        .bias_V_ce0     (ce0),
        .bias_V_q0      (q0),
        .output_V_din   (din),
        .output_V_full_n(full_n),
        .output_V_write (wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM with one-cycle read latency
    initial q0 = '0;
    always @(posedge clk) if (ce0) q0 <= rom[addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // scoreboard state
    int m_reads = 0;
    int m_writes = 0;
    bit m_done_next = 0;
    // per-test observations
    bit active = 0;
    int mode = 0;
    int t0 = 0;
    int n_wr, n_wr_f1, n_done, first_wr, last_wr, first_done;
    int idle_r1, idle_r14;
    int got[$];

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (!rst_n) begin
            check("rst_idle", ap_idle, 1);
            check("rst_done", ap_done, 0);
            check("rst_ce0", ce0, 0);
            check("rst_addr", addr, 0);
            check("rst_write", wr, 0);
            check("rst_din", din, 0);
            m_reads = 0;
            m_writes = 0;
            m_done_next = 0;
        end else begin
            check("done_pulse", ap_done, m_done_next);
            if (active && ap_done) begin
                n_done++;
                if (first_done < 0) first_done = rel;
            end
            if (wr) begin
                check("write_needs_full_n", full_n, 1);
                check("din_order", din, rom[m_writes % KERN]);
                m_writes++;
                if (active) begin
                    got.push_back(int'(din));
                    n_wr++;
                    if (first_wr < 0) first_wr = rel;
                    if (n_done == 0) begin
                        last_wr = rel;
                        n_wr_f1++;
                    end
                end
            end
            if (ce0) begin
                check("rom_addr", addr, m_reads % KERN);
                m_reads++;
            end
            check("outstanding_le_2", longint'((m_reads - m_writes) <= 2), 1);
            m_done_next = wr && (m_writes % (KERN * PIX) == 0);
            if (active && rel == 1) idle_r1 = ap_idle;
            if (active && rel == 14) idle_r14 = ap_idle;
            if (active && mode == 1 && rel >= 4 && rel <= 7) begin
                check("stall_write", wr, 0);
                check("stall_din", din, 30);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ap_start = 1'b0;
        full_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_before_start", ap_idle, 1);
    endtask

    // md: 0 plain, 1 stall 4-7, 2 full_n toggle, 3 reset at 6, 4 start held
    task automatic run(input int md, input int ncyc, input int start_hold);
        mode = md;
        n_wr = 0; n_wr_f1 = 0; n_done = 0;
        first_wr = -1; last_wr = -1; first_done = -1;
        idle_r1 = -1; idle_r14 = -1;
        got.delete();
        for (int r = 0; r <= ncyc; r++) begin
            @(posedge clk);
            #1;
            if (r == 0) begin
                t0 = cyc;
                active = 1'b1;
            end
            ap_start = (r <= start_hold);
            case (md)
                1: full_n = !(r >= 4 && r <= 7);
                2: full_n = (r % 2 == 0);
                default: full_n = 1'b1;
            endcase
            if (md == 3 && r == 6) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_idle", ap_idle, 1);
                check("async_rst_ce0", ce0, 0);
                check("async_rst_addr", addr, 0);
                check("async_rst_write", wr, 0);
                check("async_rst_din", din, 0);
            end
            if (md == 3 && r == 9) rst_n = 1'b1;
        end
        @(negedge clk);
        #1;
        active = 1'b0;
        ap_start = 1'b0;
        full_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        ap_start = 1'b0;
        full_n = 1'b1;

        // basic frame at full throughput
        do_reset();
        run(0, 16, 0);
        check("t1_first_write_cycle", first_wr, 2);
        check("t1_last_write_cycle", last_wr, 13);
        check("t1_done_cycle", first_done, 14);
        check("t1_word_count", n_wr_f1, 12);
        check("t1_word0", got[0], 10);
        check("t1_word1", got[1], 20);
        check("t1_word2", got[2], 30);
        check("t1_word3", got[3], 40);
        check("t1_word4", got[4], 10);
        check("t1_word11", got[11], 40);
        check("t1_idle_cycle1", idle_r1, 0);
        check("t1_done_count", n_done, 1);
`ifndef BIAS_STREAM_LOOP_EN
        check("t1_idle_cycle14", idle_r14, 1);
        check("t1_no_extra_words", n_wr, 12);
`endif

        // back-pressure on cycles 4..7
        do_reset();
        run(1, 20, 0);
        check("t2_word_count", n_wr_f1, 12);
        check("t2_done_cycle", first_done, 18);
        check("t2_word2", got[2], 30);
        check("t2_word3", got[3], 40);
        check("t2_word11", got[11], 40);

        // full_n toggling every cycle
        do_reset();
        run(2, 40, 0);
        check("t3_word_count", n_wr_f1, 12);
        check("t3_word5", got[5], 20);
        check("t3_word11", got[11], 40);
        check("t3_done_seen", longint'(first_done > 0), 1);

        // reset mid-frame, then a fresh frame
        do_reset();
        run(3, 12, 0);
        check("t4_words_before_reset", n_wr, 4);
        run(0, 16, 0);
        check("t4_fresh_first_word", got[0], 10);
        check("t4_fresh_first_cycle", first_wr, 2);
        check("t4_fresh_word_count", n_wr_f1, 12);
        check("t4_fresh_done_cycle", first_done, 14);

        // ap_start held high
        do_reset();
`ifdef BIAS_STREAM_LOOP_EN
        run(4, 27, 2);
        check("t5_loop_done_count", n_done, 2);
        check("t5_loop_word_count", n_wr, 24);
        check("t5_loop_idle_cycle14", idle_r14, 0);
        check("t5_loop_word23", got[23], 40);
`else
        run(4, 30, 8);
        check("t5_done_count", n_done, 1);
        check("t5_word_count", n_wr, 12);
        check("t5_done_cycle", first_done, 14);
        check("t5_idle_end", ap_idle, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
